// File: rtl/rle_decompressor_if.sv
// rle_decompressor_if: token input, flush request and word output bundle of the RLE decompressor.
//   master: drives in_data, in_valid, flush, out_ready; observes in_ready, out_data, out_valid, out_last, busy.
//   slave : the decompressor side of the same signals.
interface rle_decompressor_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
);
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;
   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, out_last, busy
   );
   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/rle_decompressor.sv
// rle_decompressor: expands {bit, run length} tokens into LSB-first packed OUT_W-bit words.
//   clk, rst_n : rising-edge clock, synchronous active-low reset.
//   io (slave) : in_data/in_valid/in_ready token input, flush level request,
//                out_data/out_valid/out_ready/out_last word output, busy status.
module rle_decompressor #(
   parameter int OUT_W = 16,
   parameter int IN_W  = 16
) (
   input logic         clk,
   input logic         rst_n,
   rle_decompressor_if.slave io
);
   localparam int RW = IN_W - 1;
   localparam int FW = $clog2(OUT_W + 1);
   localparam int CW = (RW > FW ? RW : FW) + 1;
   typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;
   state_t           state;
   logic [OUT_W-1:0] acc, seg, next_acc;
   logic [FW-1:0]    fill;
   logic [RW-1:0]    run_left;
   logic             run_val;
   logic [CW-1:0]    room, n;
   logic             full, run_done, buf_free;
   assign io.in_ready = state == IDLE && !io.flush;
   assign io.busy     = state != IDLE;
   assign buf_free    = !io.out_valid || io.out_ready;
   // One segment per cycle: as many bits as fit before the next word boundary.
   // acc is kept zero above fill, so the segment is simply ORed in.
   always_comb begin
      room = CW'(OUT_W) - CW'(fill);
      n    = CW'(run_left) < room ? CW'(run_left) : room;
      seg  = '0;
      for (int i = 0; i < OUT_W; i++)
         seg[i] = run_val && CW'(i) >= CW'(fill) && CW'(i) < CW'(fill) + n;
      next_acc = acc | seg;
      full     = n == room;
      run_done = CW'(run_left) == n;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         fill         <= '0;
         run_left     <= '0;
         run_val      <= 1'b0;
         io.out_data  <= '0;
         io.out_valid <= 1'b0;
         io.out_last  <= 1'b0;
      end else begin
         if (io.out_valid && io.out_ready) begin
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (io.flush) begin
                  if (fill != '0) state <= FLUSH;
               end else if (io.in_valid && io.in_data[RW-1:0] != '0) begin
                  run_val  <= io.in_data[IN_W-1];
                  run_left <= io.in_data[RW-1:0];
                  state    <= EXPAND;
               end
            end
            EXPAND: begin
               if (!full || buf_free) begin
                  run_left <= run_left - RW'(n);
                  if (run_done) state <= IDLE;
               end
               if (!full) begin
                  acc  <= next_acc;
                  fill <= fill + FW'(n);
               end else if (buf_free) begin
                  io.out_data  <= next_acc;
                  io.out_valid <= 1'b1;
                  io.out_last  <= 1'b0;
                  acc          <= '0;
                  fill         <= '0;
               end
            end
            FLUSH: begin
               if (buf_free) begin
                  io.out_data  <= acc;
                  io.out_valid <= 1'b1;
                  io.out_last  <= 1'b1;
                  acc          <= '0;
                  fill         <= '0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
